// File: rtl/prod_accum.sv
// prod_accum: groups a multiplier product stream into dot-product sums with a registered valid/ready result.
// Define PROD_ACCUM_SAT_EN to make the adder saturate instead of wrapping.
module prod_accum #(
  parameter int PW  = 8,
  parameter int AW  = 10,
  parameter int LEN = 4,
  parameter int CW  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [CW-1:0] out_cnt,
  output logic          out_ovf
);
  typedef enum logic {ACC, HOLD} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] acc, sum_nxt;
  logic [CW-1:0] cnt;
  logic          ovf, accept, fin;
  logic [AW:0]   nxt;
  assign in_ready  = (state == ACC) || (state == HOLD && out_ready);
  assign accept    = in_valid && in_ready;
  assign nxt       = {1'b0, acc} + (AW+1)'(in_prod);
  assign fin       = in_last || cnt == CW'(LEN - 1);
  assign out_valid = state == HOLD;
`ifdef PROD_ACCUM_SAT_EN
  assign sum_nxt = nxt[AW] ? '1 : nxt[AW-1:0];
`else
  assign sum_nxt = nxt[AW-1:0];
`endif
  // A drain with a simultaneous non-final accept lands in ACC; a final accept always lands in HOLD.
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = fin ? HOLD : ACC;
    else if (out_ready) state_nxt = ACC;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ACC;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else if (accept && fin) begin
      out_sum <= sum_nxt;
      out_cnt <= cnt + CW'(1);
      out_ovf <= ovf | nxt[AW];
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else if (accept) begin
      acc <= sum_nxt;
      cnt <= cnt + CW'(1);
      ovf <= ovf | nxt[AW];
    end
  end
endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed checks of prod_accum using a default, a 9-bit-accumulator and a single-term instance.
module tb_prod_accum;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_last = 0, out_ready = 0;
  logic [7:0] in_prod = 0;
  logic m_rdy, m_vld, m_ovf, w_rdy, w_vld, w_ovf, s_rdy, s_vld, s_ovf;
  logic [9:0] m_sum, s_sum;
  logic [8:0] w_sum;
  logic [2:0] m_cnt, w_cnt, s_cnt;
  logic rdy_b;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  prod_accum m_dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_rdy), .in_prod(in_prod),
    .in_last(in_last), .out_valid(m_vld), .out_ready(out_ready), .out_sum(m_sum), .out_cnt(m_cnt), .out_ovf(m_ovf));
  prod_accum #(.AW(9)) w_dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_rdy), .in_prod(in_prod),
    .in_last(in_last), .out_valid(w_vld), .out_ready(out_ready), .out_sum(w_sum), .out_cnt(w_cnt), .out_ovf(w_ovf));
  prod_accum #(.LEN(1)) s_dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_rdy), .in_prod(in_prod),
    .in_last(in_last), .out_valid(s_vld), .out_ready(out_ready), .out_sum(s_sum), .out_cnt(s_cnt), .out_ovf(s_ovf));

  // Drive one cycle of inputs, record default-instance in_ready before the edge, then settle past the edge.
  task automatic cyc(input logic v, input logic [7:0] p, input logic l, input logic r);
    in_valid = v; in_prod = p; in_last = l; out_ready = r;
    #1 rdy_b = m_rdy;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    in_valid = 0; out_ready = 0; rst = 1;
    @(posedge clk); #1 rst = 0; #1;
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if (m_vld !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", m_vld); end
    n_chk++; if (m_sum !== 10'd0 || m_cnt !== 3'd0 || m_ovf !== 1'b0) begin n_fail++;
      $display("FAIL reset_outs got sum=%0d cnt=%0d ovf=%0b want 0/0/0", m_sum, m_cnt, m_ovf); end
    @(posedge clk); #1 rst = 0; #1;
    n_chk++; if (m_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", m_rdy); end
  endtask

  task automatic test_full_group();
    pulse_reset();
    repeat (3) cyc(1, 8'd225, 0, 1);
    n_chk++; if (m_vld !== 1'b0) begin n_fail++; $display("FAIL full_early_valid got %0b want 0", m_vld); end
    cyc(1, 8'd225, 0, 1);
    n_chk++; if (m_vld !== 1'b1) begin n_fail++; $display("FAIL full_valid got %0b want 1", m_vld); end
    n_chk++; if (m_sum !== 10'd900 || m_cnt !== 3'd4 || m_ovf !== 1'b0) begin n_fail++;
      $display("FAIL full_result got sum=%0d cnt=%0d ovf=%0b want 900/4/0", m_sum, m_cnt, m_ovf); end
    cyc(0, 8'd0, 0, 1);
    n_chk++; if (m_vld !== 1'b0) begin n_fail++; $display("FAIL full_one_cycle got %0b want 0", m_vld); end
  endtask

  task automatic test_last();
    pulse_reset();
    cyc(1, 8'd6, 0, 1);
    cyc(1, 8'd10, 1, 1);
    n_chk++; if (m_vld !== 1'b1 || m_sum !== 10'd16 || m_cnt !== 3'd2) begin n_fail++;
      $display("FAIL last_result got v=%0b sum=%0d cnt=%0d want 1/16/2", m_vld, m_sum, m_cnt); end
    cyc(0, 8'd0, 0, 1);
    cyc(1, 8'd7, 1, 1);
    n_chk++; if (m_vld !== 1'b1 || m_sum !== 10'd7 || m_cnt !== 3'd1) begin n_fail++;
      $display("FAIL last_fresh got v=%0b sum=%0d cnt=%0d want 1/7/1", m_vld, m_sum, m_cnt); end
    cyc(0, 8'd0, 0, 1);
  endtask

  task automatic test_backpressure();
    int bad = 0;
    pulse_reset();
    cyc(1, 8'd20, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'd99, 0, 0);
      if (rdy_b !== 1'b0 || m_vld !== 1'b1 || m_sum !== 10'd20 || m_cnt !== 3'd1) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    cyc(1, 8'd5, 0, 1);
    n_chk++; if (rdy_b !== 1'b1 || m_vld !== 1'b0) begin n_fail++;
      $display("FAIL bp_drain got rdy=%0b v=%0b want 1/0", rdy_b, m_vld); end
    cyc(1, 8'd3, 1, 1);
    n_chk++; if (m_vld !== 1'b1 || m_sum !== 10'd8 || m_cnt !== 3'd2) begin n_fail++;
      $display("FAIL bp_next got v=%0b sum=%0d cnt=%0d want 1/8/2", m_vld, m_sum, m_cnt); end
    cyc(0, 8'd0, 0, 1);
  endtask

  task automatic test_overflow();
    logic [8:0] want;
`ifdef PROD_ACCUM_SAT_EN
    want = 9'd511;
`else
    want = 9'd388;
`endif
    pulse_reset();
    repeat (4) cyc(1, 8'd225, 0, 1);
    n_chk++; if (w_vld !== 1'b1 || w_sum !== want || w_cnt !== 3'd4 || w_ovf !== 1'b1) begin n_fail++;
      $display("FAIL ovf_result got v=%0b sum=%0d cnt=%0d ovf=%0b want 1/%0d/4/1", w_vld, w_sum, w_cnt, w_ovf, want); end
    cyc(1, 8'd5, 1, 1);
    n_chk++; if (w_sum !== 9'd5 || w_ovf !== 1'b0) begin n_fail++;
      $display("FAIL ovf_clear got sum=%0d ovf=%0b want 5/0", w_sum, w_ovf); end
    cyc(0, 8'd0, 0, 1);
  endtask

  task automatic test_back_to_back();
    logic [9:0] v [3];
    int bad = 0;
    v = '{10'd3, 10'd5, 10'd7};
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, v[i][7:0], 0, 1);
      if (s_vld !== 1'b1 || s_sum !== v[i] || s_cnt !== 3'd1) begin bad++;
        $display("FAIL b2b_beat%0d got v=%0b sum=%0d cnt=%0d want 1/%0d/1", i, s_vld, s_sum, s_cnt, v[i]); end
    end
    n_chk++; if (bad != 0) n_fail++;
    cyc(0, 8'd0, 0, 1);
    n_chk++; if (s_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %0b want 0", s_vld); end
  endtask

  task automatic test_mid_reset();
    pulse_reset();
    cyc(1, 8'd9, 1, 0);
    cyc(0, 8'd0, 0, 1);
    cyc(1, 8'd100, 0, 1);
    cyc(1, 8'd50, 0, 1);
    rst = 1; #2;
    n_chk++; if (m_sum !== 10'd0 || m_cnt !== 3'd0 || m_vld !== 1'b0) begin n_fail++;
      $display("FAIL mid_rst_outs got sum=%0d cnt=%0d v=%0b want 0/0/0", m_sum, m_cnt, m_vld); end
    n_chk++; if (s_vld !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hold got %0b want 0", s_vld); end
    @(posedge clk); #1 rst = 0; #1;
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0, 1);
    n_chk++; if (m_vld !== 1'b1 || m_sum !== 10'd10 || m_cnt !== 3'd4) begin n_fail++;
      $display("FAIL mid_rst_sum got v=%0b sum=%0d cnt=%0d want 1/10/4", m_vld, m_sum, m_cnt); end
    cyc(0, 8'd0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_last();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prod_accum.md
Name: prod_accum

Overview:
- Downstream consumer of the 4x4 combinational multiplier. Accepts its 8-bit product stream over a valid/ready handshake.
- Sums products into groups (dot products) of up to LEN terms. A group can close early on in_last.
- Presents each group sum with a term count on a registered valid/ready output for the next stage.

Parameters:
PW, 8, product width (matches multiplier output o)
AW, 10, accumulator/result width (900 = 4*225 fits in 10 bits)
LEN, 4, maximum terms per group, >=1
CW, 3, count width, must hold LEN

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  product beat valid
in_ready  output  1  block can accept a beat this cycle
in_prod  input  PW  unsigned product from multiplier
in_last  input  1  beat closes the current group early
out_valid  output  1  group result valid
out_ready  input  1  downstream accepts result
out_sum  output  AW  group sum
out_cnt  output  CW  number of terms in group (1..LEN)
out_ovf  output  1  group sum exceeded 2^AW-1 at some point

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - state=ACC, acc=0, cnt=0, ovf=0.
  - out_valid=0, out_sum=0, out_cnt=0, out_ovf=0.
  - in_ready=1 after reset deasserts.
- States:
  - ACC: gathering a group, output empty.
  - HOLD: result registered, out_valid=1.
- in_ready = (state==ACC) | (state==HOLD & out_ready). It is combinational from state and out_ready only, never from in_valid.
- Accept = in_valid & in_ready.
- On accept:
  - nxt = acc + zero-extended in_prod, computed AW+1 wide.
  - The beat is final if in_last=1 or cnt==LEN-1.
- Accept of a non-final beat: acc<=nxt[AW-1:0], cnt<=cnt+1, ovf<=ovf|nxt[AW]. State stays ACC. If it came from HOLD with out_ready, the output is consumed that same cycle and state goes to ACC.
- Accept of a final beat:
  - out_sum<=nxt[AW-1:0], out_cnt<=cnt+1, out_ovf<=ovf|nxt[AW], out_valid<=1.
  - acc<=0, cnt<=0, ovf<=0.
  - State goes to HOLD.
- Latency: out_valid rises on the edge after the final beat is accepted, i.e. 1 cycle.
- HOLD & out_ready & no accept: out_valid<=0, state goes to ACC. Output registers keep their old value (don't-care while invalid).
- HOLD & out_ready & accept (simultaneous drain/fill):
  - The old result is consumed and the new beat starts a fresh group. acc was already 0, so there is no bubble.
  - If that beat is also final (LEN=1 or in_last), HOLD persists with the new result and out_valid stays 1.
- HOLD & !out_ready: in_ready=0. out_sum, out_cnt and out_ovf are held stable, and in_prod is ignored.
- in_valid=0: no state change, except the HOLD drain described above.
- Arithmetic: unsigned. Without the optional feature the sum wraps mod 2^AW. Overflow is flagged via out_ovf, sticky within the group and cleared at group close.
- in_last on a beat at cnt==LEN-1 is redundant and gives the same result.
- Reset mid-group or in HOLD discards the partial sum and any pending result. out_valid drops asynchronously.

Optional Feature:
- Macro PROD_ACCUM_SAT_EN.
- Defined:
  - Every add saturates: if nxt[AW]=1, the stored value is 2^AW-1. Later adds stay clamped.
  - out_ovf still reports that saturation occurred.
- Undefined: wrap-around as described above.
- Port list is identical either way.

Test Plan:
- 4 beats 225,225,225,225 with out_ready=1 -> one result: out_sum=900, out_cnt=4, out_ovf=0; out_valid high exactly 1 cycle.
- Beats 6,10 with in_last on the second beat -> out_sum=16, out_cnt=2; the next group starts from 0.
- Result pending, out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout; out_sum is held and no beats are lost. Raise out_ready -> result consumed and first new beat accepted the same cycle.
- AW=9 with beats 225 x4:
  - without macro: out_sum=900-512=388, out_ovf=1;
  - with PROD_ACCUM_SAT_EN: out_sum=511, out_ovf=1.
- LEN=1 back-to-back beats 3,5,7 with out_ready=1 -> out_valid continuously high; outputs 3,5,7 on consecutive cycles, each with out_cnt=1.
- Assert rst after 2 of 4 beats (values 100,50) -> outputs return to 0 immediately. Beats 1,2,3,4 then yield out_sum=10, not 160.
